multiword_add_sequencer: RTL and testbench

Sequential wrapper that runs multi-precision additions through the team's `N_bit_Parallel` word adder, one WIDTH-bit word pair per cycle. Words arrive least significant first. The carry out of each word is registered and fed back as the carry in of the next word. It sits directly around the adder: it feeds the adder's `in1`/`in2`/`ic` and consumes its `out`/`oc`, adding valid/ready handshakes on both sides and a one-stage output register.

---
 rtl/add_seq_pkg.sv | 13 +
 rtl/N_bit_Parallel.sv | 24 ++
 rtl/multiword_add_sequencer.sv | 115 +++++++++++
 tb/tb_multiword_add_sequencer.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_seq_pkg.sv
// Shared types and default sizing for the multi-word add sequencer.
package add_seq_pkg;

   localparam int unsigned ADD_WIDTH = 4;
   localparam int unsigned ADD_WORDS = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/N_bit_Parallel.sv
// Ripple-carry word adder; oc[i] is the carry out of bit i, oc[WIDTH-1] the word carry.
module N_bit_Parallel #(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             ic,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] oc
);

   always_comb begin
      logic c;
      c   = ic;
      out = '0;
      oc  = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         out[i] = in1[i] ^ in2[i] ^ c;
         c      = (in1[i] & in2[i]) | (c & (in1[i] ^ in2[i]));
         oc[i]  = c;
      end
   end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Multi-precision adder: one word pair per cycle, LS word first, carry chained
// through a register, with valid/ready on both sides and a registered sum word.
module multiword_add_sequencer
   import add_seq_pkg::*;
#(
   parameter int unsigned WIDTH = ADD_WIDTH,
   parameter int unsigned WORDS = ADD_WORDS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             ic,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             out_last,
   output logic             oc,
   output logic             busy
);

   localparam int unsigned   CNT_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

   state_e           state;
   logic             carry;
   logic [CNT_W-1:0] cnt;

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] carries;
   logic             carry_out;
   logic             accept;
   logic             out_fire;
   logic             unused_carries;

   N_bit_Parallel #(
      .WIDTH (WIDTH)
   ) u_adder (
      .in1 (in1),
      .in2 (in2),
      .ic  (carry),
      .out (sum),
      .oc  (carries)
   );

   // Only the word carry is needed; the per-bit carries are intentionally dropped.
   assign carry_out      = carries[WIDTH-1];
   assign unused_carries = ^carries;

   assign in_ready = (state == RUN) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         carry     <= 1'b0;
         cnt       <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         oc        <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  carry <= ic;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end

            RUN: begin
               if (accept) begin
                  out       <= sum;
                  out_valid <= 1'b1;
                  carry     <= carry_out;
                  if (cnt == LAST_CNT) begin
                     // Final word: counter parks at zero rather than wrapping.
                     cnt      <= '0;
                     out_last <= 1'b1;
                     oc       <= carry_out;
                     state    <= DRAIN;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end else if (out_fire) begin
                  out_valid <= 1'b0;
               end
            end

            DRAIN: begin
               if (out_fire) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  oc        <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench: directed scenarios plus random operations against a
// whole-number addition model of the multi-word sum.
module tb_multiword_add_sequencer;
   import add_seq_pkg::*;

   localparam int unsigned W     = ADD_WIDTH;
   localparam int unsigned WORDS = ADD_WORDS;
   localparam int unsigned TOT   = W * WORDS;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         ic = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in1 = '0;
   logic [W-1:0] in2 = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out;
   logic         out_last;
   logic         oc;
   logic         busy;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] got_out[$];
   logic         got_last[$];
   logic         got_oc[$];
   int           last_cycles;
   logic         last_busy;

   multiword_add_sequencer #(
      .WIDTH (W),
      .WORDS (WORDS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .ic        (ic),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in1       (in1),
      .in2       (in2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .out_last  (out_last),
      .oc        (oc),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Whole operands as plain integers: the reference is a single wide addition.
   function automatic logic [TOT:0] ref_sum(input logic [TOT-1:0] a, input logic [TOT-1:0] b,
                                            input logic c);
      return {1'b0, a} + {1'b0, b} + {{TOT{1'b0}}, c};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drives words from first_idx on while in RUN, collecting every output handshake.
   task automatic stream_op(input logic [TOT-1:0] a, input logic [TOT-1:0] b,
                            input int rdy_pct, input int vld_pct, input bit noise,
                            input int first_idx);
      int idx;
      int cyc;
      idx = first_idx;
      cyc = 0;
      got_out.delete();
      got_last.delete();
      got_oc.delete();
      while (got_out.size() < WORDS && cyc < 200) begin
         if (idx < int'(WORDS)) begin
            in_valid = (int'($urandom_range(99)) < vld_pct);
            in1      = a[idx*W +: W];
            in2      = b[idx*W +: W];
         end else begin
            in_valid = noise ? 1'($urandom_range(1)) : 1'b0;
            in1      = W'($urandom);
            in2      = W'($urandom);
         end
         out_ready = (int'($urandom_range(99)) < rdy_pct);
         if (noise) begin
            start = 1'($urandom_range(1));
            ic    = 1'($urandom_range(1));
         end
         #1;
         last_busy = busy;
         if (out_valid && out_ready) begin
            got_out.push_back(out);
            got_last.push_back(out_last);
            got_oc.push_back(oc);
         end
         if (in_valid && in_ready) idx++;
         tick;
         cyc++;
      end
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      start       = 1'b0;
      ic          = 1'b0;
      last_cycles = cyc;
   endtask

   task automatic run_op(input logic [TOT-1:0] a, input logic [TOT-1:0] b, input logic c,
                         input int rdy_pct, input int vld_pct);
      start    = 1'b1;
      ic       = c;
      in_valid = 1'b0;
      tick;
      start = 1'b0;
      ic    = 1'b0;
      stream_op(a, b, rdy_pct, vld_pct, 1'b0, 0);
   endtask

   task automatic test_reset;
      rst       = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick;
      tick;
      checks++;
      if ({in_ready, out_valid, out, out_last, oc, busy} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got in_ready=%b out_valid=%b out=%h last=%b oc=%b busy=%b exp all 0",
                  in_ready, out_valid, out, out_last, oc, busy);
      end
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tick;
   endtask

   task automatic test_basic;
      logic [W-1:0] exp_w[4] = '{4'h3, 4'h4, 4'h0, 4'h0};
      run_op(16'h001A, 16'h0029, 1'b0, 100, 100);
      checks++;
      if (got_out.size() != WORDS) begin
         failures++;
         $display("FAIL basic_count got=%0d exp=%0d", got_out.size(), WORDS);
      end else begin
         for (int k = 0; k < int'(WORDS); k++) begin
            checks++;
            if ({got_out[k], got_last[k], got_oc[k]} !== {exp_w[k], 1'(k == int'(WORDS) - 1), 1'b0}) begin
               failures++;
               $display("FAIL basic_word%0d got out=%h last=%b oc=%b exp out=%h last=%b oc=0",
                        k, got_out[k], got_last[k], got_oc[k], exp_w[k], k == int'(WORDS) - 1);
            end
         end
      end
   endtask

   task automatic test_ripple;
      run_op(16'hFFFF, 16'h0000, 1'b1, 100, 100);
      checks++;
      if (got_out.size() != WORDS) begin
         failures++;
         $display("FAIL ripple_count got=%0d exp=%0d", got_out.size(), WORDS);
      end else begin
         for (int k = 0; k < int'(WORDS); k++) begin
            checks++;
            if ({got_out[k], got_last[k], got_oc[k]} !== {4'h0, 1'(k == int'(WORDS) - 1), 1'(k == int'(WORDS) - 1)}) begin
               failures++;
               $display("FAIL ripple_word%0d got out=%h last=%b oc=%b exp out=0 last=oc=%b",
                        k, got_out[k], got_last[k], got_oc[k], k == int'(WORDS) - 1);
            end
         end
      end
   endtask

   task automatic test_backpressure;
      logic [TOT-1:0] a = 16'h001A;
      logic [TOT-1:0] b = 16'h0029;
      logic [W-1:0]   exp_w[4] = '{4'h3, 4'h4, 4'h0, 4'h0};
      start = 1'b1;
      ic    = 1'b0;
      tick;
      start     = 1'b0;
      in_valid  = 1'b1;
      in1       = 4'hA;
      in2       = 4'h9;
      out_ready = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_first_ready got=%b exp=1", in_ready);
      end
      tick;
      in1 = 4'h1;
      in2 = 4'h2;
      for (int h = 0; h < 3; h++) begin
         #1;
         checks++;
         if ({out_valid, out, in_ready} !== {1'b1, 4'h3, 1'b0}) begin
            failures++;
            $display("FAIL bp_hold%0d got valid=%b out=%h in_ready=%b exp valid=1 out=3 in_ready=0",
                     h, out_valid, out, in_ready);
         end
         tick;
      end
      stream_op(a, b, 100, 100, 1'b0, 1);
      checks++;
      if (got_out.size() != WORDS) begin
         failures++;
         $display("FAIL bp_count got=%0d exp=%0d", got_out.size(), WORDS);
      end else begin
         for (int k = 0; k < int'(WORDS); k++) begin
            checks++;
            if ({got_out[k], got_last[k]} !== {exp_w[k], 1'(k == int'(WORDS) - 1)}) begin
               failures++;
               $display("FAIL bp_word%0d got out=%h last=%b exp out=%h last=%b",
                        k, got_out[k], got_last[k], exp_w[k], k == int'(WORDS) - 1);
            end
         end
      end
   endtask

   task automatic test_reset_mid;
      start = 1'b1;
      ic    = 1'b1;
      tick;
      start     = 1'b0;
      ic        = 1'b0;
      in_valid  = 1'b1;
      in1       = 4'hF;
      in2       = 4'hF;
      out_ready = 1'b1;
      tick;
      tick;
      in_valid = 1'b0;
      rst      = 1'b1;
      tick;
      checks++;
      if ({in_ready, out_valid, out, out_last, oc, busy} !== '0) begin
         failures++;
         $display("FAIL midreset_outputs got in_ready=%b out_valid=%b out=%h last=%b oc=%b busy=%b exp all 0",
                  in_ready, out_valid, out, out_last, oc, busy);
      end
      rst       = 1'b0;
      out_ready = 1'b0;
      tick;
      run_op(16'h1111, 16'h1111, 1'b0, 100, 100);
      checks++;
      if (got_out.size() != WORDS) begin
         failures++;
         $display("FAIL midreset_count got=%0d exp=%0d", got_out.size(), WORDS);
      end else begin
         for (int k = 0; k < int'(WORDS); k++) begin
            checks++;
            if ({got_out[k], got_oc[k]} !== {4'h2, 1'b0}) begin
               failures++;
               $display("FAIL midreset_word%0d got out=%h oc=%b exp out=2 oc=0", k, got_out[k], got_oc[k]);
            end
         end
      end
   endtask

   task automatic test_ignored;
      logic [TOT-1:0] a;
      logic [TOT-1:0] b;
      logic [TOT:0]   exp;
      in_valid  = 1'b1;
      in1       = 4'h5;
      in2       = 4'h5;
      out_ready = 1'b1;
      tick;
      tick;
      checks++;
      if ({out_valid, busy, in_ready} !== 3'b000) begin
         failures++;
         $display("FAIL idle_valid got valid=%b busy=%b in_ready=%b exp 0 0 0", out_valid, busy, in_ready);
      end
      start = 1'b1;
      ic    = 1'b0;
      tick;
      start    = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++;
      if ({busy, out_valid} !== 2'b10) begin
         failures++;
         $display("FAIL start_with_valid got busy=%b valid=%b exp busy=1 valid=0", busy, out_valid);
      end
      tick;
      a   = TOT'($urandom);
      b   = TOT'($urandom);
      exp = ref_sum(a, b, 1'b0);
      stream_op(a, b, 80, 80, 1'b1, 0);
      checks++;
      if (got_out.size() != WORDS) begin
         failures++;
         $display("FAIL noise_count got=%0d exp=%0d", got_out.size(), WORDS);
      end else begin
         for (int k = 0; k < int'(WORDS); k++) begin
            checks++;
            if ({got_out[k], got_last[k], got_oc[k]} !==
                {exp[k*W +: W], 1'(k == int'(WORDS) - 1), (k == int'(WORDS) - 1) ? exp[TOT] : 1'b0}) begin
               failures++;
               $display("FAIL noise_word%0d got out=%h last=%b oc=%b exp out=%h", k, got_out[k],
                        got_last[k], got_oc[k], exp[k*W +: W]);
            end
         end
      end
   endtask

   task automatic test_streaming;
      logic [TOT-1:0] a = TOT'($urandom);
      logic [TOT-1:0] b = TOT'($urandom);
      logic           c = 1'($urandom_range(1));
      logic [TOT:0]   exp;
      exp       = ref_sum(a, b, c);
      start     = 1'b1;
      ic        = c;
      tick;
      start     = 1'b0;
      ic        = 1'b0;
      out_ready = 1'b1;
      #1;
      checks++;
      if ({busy, in_ready} !== 2'b11) begin
         failures++;
         $display("FAIL stream_start got busy=%b in_ready=%b exp 1 1", busy, in_ready);
      end
      stream_op(a, b, 100, 100, 1'b0, 0);
      checks++;
      if (last_cycles != int'(WORDS) + 1) begin
         failures++;
         $display("FAIL stream_cycles got=%0d exp=%0d", last_cycles, WORDS + 1);
      end
      checks++;
      if ({last_busy, busy} !== 2'b10) begin
         failures++;
         $display("FAIL stream_busy_drop got before=%b after=%b exp 1 0", last_busy, busy);
      end
      checks++;
      if (got_out.size() != WORDS) begin
         failures++;
         $display("FAIL stream_count got=%0d exp=%0d", got_out.size(), WORDS);
      end else begin
         for (int k = 0; k < int'(WORDS); k++) begin
            checks++;
            if ({got_out[k], got_last[k], got_oc[k]} !==
                {exp[k*W +: W], 1'(k == int'(WORDS) - 1), (k == int'(WORDS) - 1) ? exp[TOT] : 1'b0}) begin
               failures++;
               $display("FAIL stream_word%0d got out=%h last=%b oc=%b exp out=%h", k, got_out[k],
                        got_last[k], got_oc[k], exp[k*W +: W]);
            end
         end
      end
   endtask

   task automatic test_random;
      logic [TOT-1:0] a;
      logic [TOT-1:0] b;
      logic           c;
      logic [TOT:0]   exp;
      for (int n = 0; n < 40; n++) begin
         a   = TOT'($urandom);
         b   = TOT'($urandom);
         c   = 1'($urandom_range(1));
         exp = ref_sum(a, b, c);
         run_op(a, b, c, 60, 70);
         checks++;
         if (got_out.size() != WORDS) begin
            failures++;
            $display("FAIL random%0d_count got=%0d exp=%0d", n, got_out.size(), WORDS);
         end else begin
            for (int k = 0; k < int'(WORDS); k++) begin
               checks++;
               if ({got_out[k], got_last[k], got_oc[k]} !==
                   {exp[k*W +: W], 1'(k == int'(WORDS) - 1), (k == int'(WORDS) - 1) ? exp[TOT] : 1'b0}) begin
                  failures++;
                  $display("FAIL random%0d_word%0d got out=%h last=%b oc=%b exp out=%h oc=%b", n, k,
                           got_out[k], got_last[k], got_oc[k], exp[k*W +: W], exp[TOT]);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_ripple;
      test_backpressure;
      test_reset_mid;
      test_ignored;
      test_streaming;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=completion");
      $fatal(1, "watchdog expired");
   end

endmodule
